// File: rtl/ahb_slave_mem_if.sv
// rtl/ahb_slave_mem_if.sv - AHB-Lite signal bundle between a bus master and ahb_slave_mem
interface ahb_slave_mem_if;
    logic [31:0] Haddr;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [31:0] Hwdata;
    logic        Hreadyin;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;

    modport slave (
        input  Haddr, Htrans, Hwrite, Hwdata, Hreadyin,
        output Hreadyout, Hresp, Hrdata
    );

    modport master (
        output Haddr, Htrans, Hwrite, Hwdata, Hreadyin,
        input  Hreadyout, Hresp, Hrdata
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite word-addressed register bank slave with wait states and ERROR response
module ahb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic           Hclk,
    input  logic           Hreset,
    ahb_slave_mem_if.slave bus
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN    = 32'(4 * DEPTH);
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_idx;
    logic            r_write;
    logic            r_hreadyout;
    logic [1:0]      r_hresp;
    logic [31:0]     r_mem [DEPTH];

    logic [31:0]     w_offset;
    logic            w_err;
    logic            w_accept;
    logic            w_unused;

    assign w_offset = bus.Haddr - BASE_ADDR;
    assign w_err    = (bus.Haddr[1:0] != 2'b00) || (bus.Haddr < BASE_ADDR) || (w_offset >= SPAN);
    // Only an open data phase (Hreadyout high) may overlap a new address phase.
    assign w_accept = bus.Hreadyin && bus.Htrans[1] && r_hreadyout;
    assign w_unused = bus.Htrans[0];

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_idx       <= '0;
            r_write     <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 2'b00;
        end else if (w_accept) begin
            r_idx   <= w_offset[AW+1:2];
            r_write <= bus.Hwrite;
            if (w_err) begin
                r_state     <= S_ERR1;
                r_hreadyout <= 1'b0;
                r_hresp     <= 2'b01;
            end else if (WAIT_STATES == 0) begin
                r_state     <= S_DONE;
                r_hreadyout <= 1'b1;
                r_hresp     <= 2'b00;
            end else begin
                r_state     <= S_WAIT;
                r_cnt       <= WS_LOAD;
                r_hreadyout <= 1'b0;
                r_hresp     <= 2'b00;
            end
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_DONE;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 2'b01;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 2'b00;
                end
            endcase
        end
    end

    // Write commits at the end of DONE, so a back-to-back read sees it.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if ((r_state == S_DONE) && r_write) begin
            r_mem[r_idx] <= bus.Hwdata;
        end
    end

    assign bus.Hreadyout = r_hreadyout;
    assign bus.Hresp     = r_hresp;
    assign bus.Hrdata    = ((r_state == S_DONE) && !r_write) ? r_mem[r_idx] : 32'd0;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - self-checking bench for ahb_slave_mem at 0, 3 and 5 wait states
module tb_ahb_slave_mem;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 16;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst    [3];
    logic [31:0] haddr  [3];
    logic [1:0]  htrans [3];
    logic        hwrite [3];
    logic [31:0] hwdata [3];
    logic        readyo [3];
    logic [1:0]  resp   [3];
    logic [31:0] rdata  [3];

    logic [31:0] mem_m [3][DEPTH];
    xfer_t       q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_slave_mem_if bus ();
        assign bus.Haddr    = haddr[g];
        assign bus.Htrans   = htrans[g];
        assign bus.Hwrite   = hwrite[g];
        assign bus.Hwdata   = hwdata[g];
        assign bus.Hreadyin = bus.Hreadyout;
        assign readyo[g]    = bus.Hreadyout;
        assign resp[g]      = bus.Hresp;
        assign rdata[g]     = bus.Hrdata;

        ahb_slave_mem #(
            .BASE_ADDR  (BASE),
            .DEPTH      (DEPTH),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 5))
        ) u_dut (
            .Hclk  (clk),
            .Hreset(rst[g]),
            .bus   (bus.slave)
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || (a > BASE + 32'(4 * DEPTH) - 32'd1);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) / 32'd4) % DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d);
        xfer_t x;
        x.addr  = a;
        x.wr    = w;
        x.wdata = d;
        q.push_back(x);
    endtask

    task automatic clear_model(input int k);
        for (int i = 0; i < DEPTH; i++) mem_m[k][i] = 32'd0;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            htrans[k] = 2'b00;
            haddr[k]  = BASE;
            hwrite[k] = 1'b0;
            hwdata[k] = 32'd0;
        end
    endtask

    // Drive the queued transfers onto DUT k; each cycle compare the bus against
    // the latency/response the model predicts for the transfer in its data phase.
    task automatic run_seq(input int k, input int idle_pct);
        xfer_t       cur;
        xfer_t       nx;
        bit          cur_v = 1'b0;
        bit          cur_err = 1'b0;
        bit          compl;
        bit          issue;
        int          cyc = 0;
        int          lat = 1;
        int          guard = 0;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rd;
        while ((q.size() != 0 || cur_v) && guard < 2000) begin
            guard++;
            compl    = !cur_v || (cyc == lat - 1);
            exp_resp = (cur_v && cur_err) ? 2'b01 : 2'b00;
            exp_rd   = (cur_v && compl && !cur_err && !cur.wr) ? mem_m[k][idx_of(cur.addr)] : 32'd0;
            chk($sformatf("d%0d_ready", k), 32'(readyo[k]), 32'(compl));
            chk($sformatf("d%0d_resp", k), 32'(resp[k]), 32'(exp_resp));
            chk($sformatf("d%0d_rdata", k), rdata[k], exp_rd);
            if (cur_v && compl && !cur_err && cur.wr) mem_m[k][idx_of(cur.addr)] = cur.wdata;
            hwdata[k] = (cur_v && cur.wr) ? cur.wdata : $urandom;
            issue = compl && (q.size() != 0) && ($urandom_range(99) >= idle_pct);
            if (issue) begin
                nx        = q.pop_front();
                haddr[k]  = nx.addr;
                hwrite[k] = nx.wr;
                htrans[k] = $urandom_range(1) ? 2'b10 : 2'b11;
            end else begin
                haddr[k]  = $urandom;
                hwrite[k] = 1'($urandom_range(1));
                htrans[k] = $urandom_range(1) ? 2'b00 : 2'b01;
            end
            @(posedge clk);
            if (issue) begin
                cur     = nx;
                cur_v   = 1'b1;
                cyc     = 0;
                cur_err = is_err(nx.addr);
                lat     = cur_err ? 2 : ws_of(k) + 1;
            end else if (compl) begin
                cur_v = 1'b0;
            end else begin
                cyc++;
            end
            @(negedge clk);
        end
        chk($sformatf("d%0d_seq_bound", k), 32'(guard < 2000), 32'd1);
        htrans[k] = 2'b00;
    endtask

    task automatic fill_random(input int n);
        xfer_t x;
        int    r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(9);
            if (r < 7)       x.addr = BASE + 32'(4 * $urandom_range(DEPTH - 1));
            else if (r == 7) x.addr = BASE + 32'(4 * $urandom_range(DEPTH - 1)) + 32'($urandom_range(3, 1));
            else if (r == 8) x.addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(7));
            else             x.addr = BASE - 32'd4 - 32'(4 * $urandom_range(7));
            x.wr    = 1'($urandom_range(1));
            x.wdata = $urandom;
            q.push_back(x);
        end
    endtask

    initial begin
        idle_all();
        for (int k = 0; k < 3; k++) begin
            rst[k]    = 1'b1;
            htrans[k] = 2'b10;
            hwrite[k] = 1'b1;
            hwdata[k] = 32'hFFFF_FFFF;
            clear_model(k);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rst%0d_ready", k), 32'(readyo[k]), 32'd1);
                chk($sformatf("rst%0d_resp", k), 32'(resp[k]), 32'd0);
                chk($sformatf("rst%0d_rdata", k), rdata[k], 32'd0);
            end
        end
        idle_all();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);

        push(BASE, 1'b0, 32'd0);
        run_seq(0, 0);

        push(BASE + 32'h4, 1'b1, 32'hDEAD_BEEF);
        run_seq(0, 0);
        push(BASE + 32'h4, 1'b0, 32'd0);
        run_seq(0, 0);

        push(BASE + 32'h8, 1'b1, 32'h1234_5678);
        push(BASE + 32'h8, 1'b0, 32'd0);
        run_seq(0, 0);

        for (int c = 0; c < 3; c++) begin
            htrans[0] = 2'b01;
            haddr[0]  = BASE + 32'h8;
            @(posedge clk);
            @(negedge clk);
            chk("busy_ready", 32'(readyo[0]), 32'd1);
            chk("busy_resp", 32'(resp[0]), 32'd0);
            chk("busy_rdata", rdata[0], 32'd0);
        end
        htrans[0] = 2'b00;

        push(BASE, 1'b1, 32'hCAFE_F00D);
        run_seq(1, 0);
        push(BASE, 1'b0, 32'd0);
        run_seq(1, 0);

        push(BASE + 32'h40, 1'b1, 32'h5555_AAAA);
        push(BASE, 1'b0, 32'd0);
        push(BASE + 32'h2, 1'b0, 32'd0);
        push(BASE + 32'h8, 1'b0, 32'd0);
        run_seq(0, 0);
        push(BASE + 32'h40, 1'b1, 32'h5555_AAAA);
        push(BASE + 32'h2, 1'b0, 32'd0);
        run_seq(2, 0);

        @(negedge clk);
        haddr[2]  = BASE + 32'hC;
        hwrite[2] = 1'b1;
        htrans[2] = 2'b10;
        @(posedge clk);
        @(negedge clk);
        htrans[2] = 2'b00;
        hwdata[2] = 32'hA5A5_A5A5;
        chk("midwait_w1_ready", 32'(readyo[2]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("midwait_w2_ready", 32'(readyo[2]), 32'd0);
        rst[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midwait_rst_ready", 32'(readyo[2]), 32'd1);
        chk("midwait_rst_resp", 32'(resp[2]), 32'd0);
        rst[2] = 1'b0;
        clear_model(2);
        @(posedge clk);
        @(negedge clk);
        push(BASE + 32'hC, 1'b0, 32'd0);
        run_seq(2, 0);

        for (int k = 0; k < 3; k++) begin
            fill_random(30);
            run_seq(k, 20);
            fill_random(30);
            run_seq(k, 0);
            for (int i = 0; i < DEPTH; i++) push(BASE + 32'(4 * i), 1'b0, 32'd0);
            run_seq(k, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- AHB-Lite responder: the target end of the bus that AHB_Master drives.
- Accepts single and back-to-back NONSEQ/SEQ word transfers into an internal word-addressed register bank.
- Inserts a configurable number of wait states; issues the two-cycle ERROR response on bad addresses.
- Serves as the stand-in slave for master-side regression and as the memory model behind the bridge.

Parameters:
BASE_ADDR, 32'h8000_0000, byte address of word 0 of the bank
DEPTH, 16, number of 32-bit words (power of two, 2..256)
WAIT_STATES, 0, Hreadyout-low cycles inserted before each OKAY completion (0..15)

Ports:
Hclk  input  1  bus clock; all state updates on rising edge
Hreset  input  1  synchronous, active-high reset
Haddr  input  32  address-phase byte address
Htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
Hwrite  input  1  address-phase direction, 1 = write
Hwdata  input  32  data-phase write data
Hreadyin  input  1  bus HREADY; address phase sampled only when 1
Hreadyout  output  1  0 = extend current data phase
Hresp  output  2  00 OKAY, 01 ERROR
Hrdata  output  32  read data, valid in the completing read cycle

Behaviour:
- Reset (Hreset=1 at a rising edge):
  - Hreadyout=1, Hresp=00, Hrdata=0.
  - All DEPTH words cleared to 0; FSM to IDLE; wait counter 0.
  - Any in-flight transfer is dropped with no memory write. This applies at every cycle, including mid-wait and mid-error.
- Address-phase acceptance: at a rising edge with Hreadyin=1 and Htrans[1]=1.
  - Registers addr_q, write_q, and the error flag.
  - The following cycle is the data phase.
  - IDLE/BUSY or Hreadyin=0: nothing captured; if no transfer is active, the output is Hreadyout=1, Hresp=00.
- Decode error if either holds:
  - Haddr[1:0] != 00.
  - Haddr outside [BASE_ADDR, BASE_ADDR + 4*DEPTH - 1].
- Word index = (Haddr - BASE_ADDR) >> 2, width log2(DEPTH).
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: counter running, Hreadyout=0, Hresp=00.
  - DONE: Hreadyout=1, Hresp=00.
  - ERR1: Hreadyout=0, Hresp=01.
  - ERR2: Hreadyout=1, Hresp=01.
- FSM transitions on acceptance:
  - Error flag set: go to ERR1, then ERR2 on the next cycle. Total latency is 2 cycles regardless of WAIT_STATES.
  - Else, WAIT_STATES=0: go to DONE.
  - Else: go to WAIT, count WAIT_STATES cycles, then DONE.
- Completion: the cycle with Hreadyout=1 in DONE or ERR2.
  - Write: Hwdata sampled in the DONE cycle and written to mem[index] at the end of that cycle.
  - Read: Hrdata = mem[index] combinationally during DONE. Hrdata = 0 in every other cycle, including ERR1/ERR2.
  - ERR writes never modify memory.
- Pipelining:
  - A new address phase presented in a completing cycle (Hreadyin=1) is accepted at that edge.
  - Next state is chosen from the new transfer, so back-to-back transfers have no idle bubble.
  - A transfer presented while Hreadyout=0 is not accepted; the master must hold it.
- Read-after-write to the same word, back-to-back: the read returns the newly written data, because the write commits at the edge before the read data phase.
- Counter rule: 4-bit counter loaded with WAIT_STATES-1 on entering WAIT, decremented each cycle; WAIT exits when it reaches 0.
- Hresp[1] is always 0 (no RETRY/SPLIT).

Test Plan:
- Reset: assert Hreset for 2 cycles with Htrans=10 -> Hreadyout=1, Hresp=00, Hrdata=0; a subsequent read of 0x8000_0000 returns 0.
- Single write then read, WAIT_STATES=0:
  - Write 0x8000_0004 with data 0xDEAD_BEEF -> Hreadyout=1 in the data phase.
  - Read of 0x8000_0004 -> Hrdata=0xDEAD_BEEF in its data-phase cycle, Hresp=00.
- Back-to-back:
  - Write 0x8000_0008 with data 0x1234_5678, immediately followed by a read of 0x8000_0008 -> read data phase Hrdata=0x1234_5678, no idle cycle between the two transfers.
  - Htrans=01 BUSY -> no state change.
- WAIT_STATES=3: read of 0x8000_0000 -> Hreadyout low for exactly 3 cycles, then high for 1 cycle with valid Hrdata.
- Errors:
  - Write 0x8000_0040 (DEPTH=16, out of range) -> Hresp=01 with Hreadyout 0 then 1; memory unchanged.
  - Read 0x8000_0002 (misaligned) -> same two-cycle ERROR response, Hrdata=0.
- Reset mid-wait: WAIT_STATES=5 write of 0xA5A5_A5A5 to 0x8000_000C, Hreset raised on the 2nd wait cycle -> next cycle Hreadyout=1; a read of 0x8000_000C returns 0.
